// File: rtl/alu_operand_arbiter.sv
// Round-robin arbiter driving the shared 8:1 operand mux select and one-hot grant toward the ALU.
// Optional ARB_LOCK_EN adds a lock_i port that keeps the grant across back-to-back transfers.

module alu_operand_arbiter_lane #(
  parameter int IDX   = 0,
  parameter int SEL_W = 3
) (
  input  logic             req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             hi_o
);
  // Request sits at or after the priority pointer, so it wins before any wrapped request.
  assign hi_o = req_i && (SEL_W'(IDX) >= ptr_i);
endmodule

module alu_operand_arbiter #(
  parameter  int N_REQ = 8,
  localparam int SEL_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             out_ready_i,
`ifdef ARB_LOCK_EN
  input  logic             lock_i,
`endif
  output logic [SEL_W-1:0] sel_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic             out_valid_o,
  output logic [N_REQ-1:0] ack_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q;
  logic [SEL_W-1:0]   ptr_q, sel_q;
  logic [N_REQ-1:0]   gnt_q, ack_q;
  logic               vld_q;
  logic [N_REQ-1:0]   hi_w;
  logic [SEL_W-1:0]   win_hi, win_any, win_d;
  logic               lock_w;

`ifdef ARB_LOCK_EN
  assign lock_w = lock_i;
`else
  assign lock_w = 1'b0;
`endif

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    alu_operand_arbiter_lane #(.IDX(i), .SEL_W(SEL_W)) u_lane (
      .req_i (req_i[i]),
      .ptr_i (ptr_q),
      .hi_o  (hi_w[i])
    );
  end

  // Lowest index wins within each half; the at-or-after-ptr half takes precedence.
  always_comb begin
    win_hi  = '0;
    win_any = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req_i[i]) win_any = SEL_W'(i);
      if (hi_w[i])  win_hi  = SEL_W'(i);
    end
    win_d = (|hi_w) ? win_hi : win_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            sel_q   <= win_d;
            gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_d;
            vld_q   <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (out_ready_i) begin
            ack_q <= gnt_q;
            // A locked handshake keeps the grant so the next transfer needs no bubble.
            if (!lock_w) begin
              ptr_q   <= sel_q + SEL_W'(1);
              gnt_q   <= '0;
              vld_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_o       = sel_q;
  assign gnt_o       = gnt_q;
  assign out_valid_o = vld_q;
  assign ack_o       = ack_q;

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Scenario bench for alu_operand_arbiter: a round-robin model pushes expected winners, acks pop them.
module tb_alu_operand_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       out_ready = 1'b0;
  logic       lock = 1'b0;
  logic [2:0] sel;
  logic [7:0] gnt, ack;
  logic       out_valid;

  int checks = 0;
  int passed = 0;
  int exp_q[$];
  logic [2:0] m_ptr = '0;

  always #5 clk = ~clk;

  alu_operand_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .out_ready_i (out_ready),
`ifdef ARB_LOCK_EN
    .lock_i      (lock),
`endif
    .sel_o       (sel),
    .gnt_o       (gnt),
    .out_valid_o (out_valid),
    .ack_o       (ack)
  );

  function automatic int rr_pick(input logic [7:0] r, input logic [2:0] p);
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (int'(p) + k) % 8;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic push_pick(input logic [7:0] r);
    int w;
    w = rr_pick(r, m_ptr);
    exp_q.push_back(w);
    m_ptr = 3'(w + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; out_ready = 1'b0; lock = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = '0;
    exp_q.delete();
  endtask

  // Runs with the current inputs until n acks are seen; checks grant outputs and popped acks.
  task automatic serve(input int n, input string name);
    int got;
    int e;
    got = 0;
    for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
      @(negedge clk);
      if (ack != 8'h00) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s_ack: got ack=%0h, expected none", name, ack);
        end else begin
          e = exp_q.pop_front();
          if (ack !== (8'h01 << e))
            $display("FAIL %s_ack: got ack=%0h, expected %0h", name, ack, 8'h01 << e);
          else passed++;
        end
        got++;
      end
      if (out_valid && exp_q.size() > 0) begin
        checks++;
        if (sel !== 3'(exp_q[0]) || gnt !== (8'h01 << exp_q[0]))
          $display("FAIL %s_grant: got sel=%0d gnt=%0h, expected sel=%0d", name, sel, gnt, exp_q[0]);
        else passed++;
      end
    end
    if (got < n) begin
      checks++;
      $display("FAIL %s_timeout: got %0d acks, expected %0d", name, got, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({sel, gnt, out_valid, ack} !== 20'h0)
      $display("FAIL reset_state: got sel=%0d gnt=%0h vld=%0b ack=%0h, expected all 0", sel, gnt, out_valid, ack);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    req = 8'h20;
    @(negedge clk);
    checks++;
    if (!out_valid || sel !== 3'd5)
      $display("FAIL reset_busy: got vld=%0b sel=%0d, expected 1/5", out_valid, sel);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, gnt, out_valid, ack} !== 20'h0)
      $display("FAIL reset_async: got sel=%0d gnt=%0h vld=%0b ack=%0h, expected all 0", sel, gnt, out_valid, ack);
    else passed++;
    req = '0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== 8'h00 || out_valid !== 1'b0)
        $display("FAIL reset_noack: got ack=%0h vld=%0b, expected 0/0", ack, out_valid);
      else passed++;
    end
    out_ready = 1'b0;
    m_ptr = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h10; out_ready = 1'b1;
    push_pick(req);
    @(negedge clk);
    checks++;
    if (!out_valid || sel !== 3'd4 || gnt !== 8'h10)
      $display("FAIL single_grant: got vld=%0b sel=%0d gnt=%0h, expected 1/4/10", out_valid, sel, gnt);
    else passed++;
    @(negedge clk);
    req = 8'h00;
    checks++;
    if (ack !== 8'h10 || out_valid !== 1'b0 || exp_q.pop_front() != 4)
      $display("FAIL single_ack: got ack=%0h vld=%0b, expected 10/0", ack, out_valid);
    else passed++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || ack !== 8'h00 || gnt !== 8'h00)
      $display("FAIL single_bubble: got vld=%0b ack=%0h gnt=%0h, expected 0/0/0", out_valid, ack, gnt);
    else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) push_pick(req);
    serve(9, "rr");
    req = 8'h00; out_ready = 1'b0;
  endtask

  task automatic test_wrap_skip();
    do_reset();
    req = 8'h20; out_ready = 1'b1;
    push_pick(req);
    serve(1, "wrap_pre");
    req = 8'h05;
    push_pick(req);
    push_pick(req);
    serve(2, "wrap");
    req = 8'h00; out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 8'h08; out_ready = 1'b0;
    push_pick(req);
    @(negedge clk);
    req = 8'h81;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (sel !== 3'd3 || !out_valid || gnt !== 8'h08 || ack !== 8'h00)
        $display("FAIL bp_hold: got sel=%0d vld=%0b gnt=%0h ack=%0h, expected 3/1/08/00", sel, out_valid, gnt, ack);
      else passed++;
    end
    req = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 8'h08 || out_valid !== 1'b0 || exp_q.pop_front() != 3)
      $display("FAIL bp_ack: got ack=%0h vld=%0b, expected 08/0", ack, out_valid);
    else passed++;
    out_ready = 1'b0;
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req = 8'h04; out_ready = 1'b1; lock = 1'b1;
    exp_q.push_back(2);
    exp_q.push_back(2);
    push_pick(8'h04);
    @(negedge clk);
    checks++;
    if (!out_valid || sel !== 3'd2 || gnt !== 8'h04)
      $display("FAIL lock_grant: got vld=%0b sel=%0d gnt=%0h, expected 1/2/04", out_valid, sel, gnt);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== 8'h04 || out_valid !== (i < 2) || exp_q.pop_front() != 2)
        $display("FAIL lock_ack%0d: got ack=%0h vld=%0b, expected 04/%0b", i, ack, out_valid, i < 2);
      else passed++;
      if (i == 1) begin
        lock = 1'b0;
        req = 8'h0C;
      end
    end
    push_pick(req);
    serve(1, "lock_next");
    req = 8'h00; out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_backpressure();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
